// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, x/y raster counters, frame
// counter, sync/active decodes and a fixed-length alignment delay for the
// sync/active copies that travel alongside framebuffer read data.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_DIV  = 2,
  parameter int PIPE_DLY = 1,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic           clka,
  input  logic           reset,
  input  logic           en,
  output logic           pix_ce,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           active_d,
  output logic           hsync_d,
  output logic           vsync_d,
  output logic           line_start,
  output logic           frame_start,
  output logic [15:0]    frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A single-cycle divider still gets a 1-bit counter that simply stays at 0.
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // {active, hsync, vsync} with every signal in its deasserted state.
  localparam logic [2:0] IDLE_SIG = {1'b0, ~HS_POL, ~VS_POL};

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             hs_raw, vs_raw;

  // Pixel tick and raster decodes, all zero-latency from the counter registers.
  always_comb begin
    pix_ce      = en && (div_cnt_q == DIV_LAST);
    active      = (x_q < X_ACT) && (y_q < Y_ACT);
    hs_raw      = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    vs_raw      = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    hsync       = HS_POL ? hs_raw : ~hs_raw;
    vsync       = VS_POL ? vs_raw : ~vs_raw;
    line_start  = pix_ce && (x_q == X_LAST);
    frame_start = line_start && (y_q == Y_LAST);
  end

  // Next-state for prescaler, raster position and frame counter.
  always_comb begin
    // NOTE: every target gets a hold value first, so no path leaves one unassigned and no latch is inferred.
    div_cnt_d   = div_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
    if (pix_ce) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d         = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Counter registers; reset wins over en so a mid-frame reset aborts the frame.
  always_ff @(posedge clka) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
    if (reset) begin
      div_cnt_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = frame_cnt_q;

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign {active_d, hsync_d, vsync_d} = {active, hsync, vsync};
    end else begin : g_dly
      logic [2:0] pipe_q [PIPE_DLY];
      logic [2:0] pipe_d [PIPE_DLY];

      // Shift the decoded signals one stage per clka, independent of en.
      always_comb begin
        pipe_d[0] = {active, hsync, vsync};
        for (int i = 1; i < PIPE_DLY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // Delay stages; all loaded with the idle pattern on reset.
      always_ff @(posedge clka) begin
        // NOTE: these stages are plain flops, not RAM, and they are reset so the delayed syncs come up deasserted.
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= IDLE_SIG;
        end else begin
          for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign {active_d, hsync_d, vsync_d} = pipe_q[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations run side by side against a
// closed-form raster model, plus directed literal checks of the key timings.
module tb_vga_timing_gen;

  typedef struct {
    longint ha, hf, hs, hb, va, vf, vs, vb;
    bit     hp, vp;
    longint pd, dly;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_err    = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT 0: defaults ----------------
  logic rst0 = 1'b1, en0 = 1'b1;
  logic pce0, act0, hs0, vs0, actd0, hsd0, vsd0, ls0, fs0;
  logic [9:0] x0, y0;
  logic [15:0] fc0;
  vga_timing_gen u_def (
    .clka(clk), .reset(rst0), .en(en0), .pix_ce(pce0), .x(x0), .y(y0),
    .active(act0), .hsync(hs0), .vsync(vs0), .active_d(actd0), .hsync_d(hsd0),
    .vsync_d(vsd0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
  );

  // ---------------- DUT 1: medium raster, PIPE_DLY=3 ----------------
  logic rst1 = 1'b1, en1 = 1'b1;
  logic pce1, act1, hs1, vs1, actd1, hsd1, vsd1, ls1, fs1;
  logic [4:0] x1, y1;
  logic [15:0] fc1;
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIX_DIV(2), .PIPE_DLY(3), .X_W(5), .Y_W(5)
  ) u_med (
    .clka(clk), .reset(rst1), .en(en1), .pix_ce(pce1), .x(x1), .y(y1),
    .active(act1), .hsync(hs1), .vsync(vs1), .active_d(actd1), .hsync_d(hsd1),
    .vsync_d(vsd1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  // ---------------- DUT 2: small raster, PIX_DIV=1, active-high syncs ----------------
  logic rst2 = 1'b1, en2 = 1'b1;
  logic pce2, act2, hs2, vs2, actd2, hsd2, vsd2, ls2, fs2;
  logic [2:0] x2, y2;
  logic [15:0] fc2;
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1), .PIPE_DLY(0), .X_W(3), .Y_W(3)
  ) u_sml (
    .clka(clk), .reset(rst2), .en(en2), .pix_ce(pce2), .x(x2), .y(y2),
    .active(act2), .hsync(hs2), .vsync(vs2), .active_d(actd2), .hsync_d(hsd2),
    .vsync_d(vsd2), .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
  );

  // Packed view of every output: {fc, x, y, pce, act, hs, vs, act_d, hs_d, vs_d, ls, fs}
  logic [44:0] dut_vec [3];
  assign dut_vec[0] = {fc0, x0, y0, pce0, act0, hs0, vs0, actd0, hsd0, vsd0, ls0, fs0};
  assign dut_vec[1] = {fc1, 5'd0, x1, 5'd0, y1, pce1, act1, hs1, vs1, actd1, hsd1, vsd1, ls1, fs1};
  assign dut_vec[2] = {fc2, 7'd0, x2, 7'd0, y2, pce2, act2, hs2, vs2, actd2, hsd2, vsd2, ls2, fs2};

  // ---------------- reference model ----------------
  cfg_t        cfg [3];
  longint      ecyc [3];
  logic [15:0] fbase [3];
  logic [2:0]  hist [3][16];
  bit          started [3];
  string       cname [3];

  function automatic cfg_t mk(input longint ha, hf, hs, hb, va, vf, vs, vb,
                              input bit hp, vp, input longint pd, dly);
    cfg_t c;
    c.ha = ha; c.hf = hf; c.hs = hs; c.hb = hb;
    c.va = va; c.vf = vf; c.vs = vs; c.vb = vb;
    c.hp = hp; c.vp = vp; c.pd = pd; c.dly = dly;
    return c;
  endfunction

  // Outputs after ec enabled clka cycles since reset, straight from the raster arithmetic.
  function automatic logic [44:0] model_vec(input cfg_t c, input longint ec, input logic e,
                                            input logic [15:0] fb, input logic [2:0] dl);
    longint ht, vt, pix, xx, yy, done;
    logic pce, act, hsr, vsr, hs, vs, ls, fs;
    logic [2:0] dd;
    logic [15:0] fc;
    ht   = c.ha + c.hf + c.hs + c.hb;
    vt   = c.va + c.vf + c.vs + c.vb;
    pix  = ec / c.pd;
    pce  = e && ((ec % c.pd) == c.pd - 1);
    xx   = pix % ht;
    yy   = (pix / ht) % vt;
    done = pix / (ht * vt);
    act  = (xx < c.ha) && (yy < c.va);
    hsr  = (xx >= c.ha + c.hf) && (xx < c.ha + c.hf + c.hs);
    vsr  = (yy >= c.va + c.vf) && (yy < c.va + c.vf + c.vs);
    hs   = c.hp ? hsr : !hsr;
    vs   = c.vp ? vsr : !vsr;
    ls   = pce && (xx == ht - 1);
    fs   = ls && (yy == vt - 1);
    fc   = fb + 16'(done);
    dd   = (c.dly == 0) ? {act, hs, vs} : dl;
    return {fc, 10'(xx), 10'(yy), pce, act, hs, vs, dd, ls, fs};
  endfunction

  function automatic logic [2:0] cur3(input cfg_t c, input longint ec);
    logic [44:0] v;
    v = model_vec(c, ec, 1'b0, 16'd0, 3'd0);
    return v[7:5];
  endfunction

  function automatic logic [2:0] idle3(input cfg_t c);
    return {1'b0, ~c.hp, ~c.vp};
  endfunction

  // Advance the model on each clka edge from the inputs the DUT sees.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if ((i == 0 && rst0) || (i == 1 && rst1) || (i == 2 && rst2)) begin
        ecyc[i]    <= 0;
        started[i] <= 1'b1;
        for (int j = 0; j < 16; j++) hist[i][j] <= idle3(cfg[i]);
      end else begin
        for (int j = 1; j < 16; j++) hist[i][j] <= hist[i][j-1];
        hist[i][0] <= cur3(cfg[i], ecyc[i]);
        if ((i == 0 && en0) || (i == 1 && en1) || (i == 2 && en2)) ecyc[i] <= ecyc[i] + 1;
      end
    end
  end

  // Compare every output of every instance on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (started[i]) begin
        check(cname[i], {19'd0, dut_vec[i]},
              {19'd0, model_vec(cfg[i], ecyc[i],
                                (i == 0) ? en0 : (i == 1) ? en1 : en2,
                                fbase[i],
                                (cfg[i].dly > 0) ? hist[i][cfg[i].dly - 1] : 3'd0)});
      end
    end
  end

  initial begin
    cfg[0] = mk(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, 1);
    cfg[1] = mk(16, 2, 4, 2, 10, 2, 2, 3, 1'b0, 1'b1, 2, 3);
    cfg[2] = mk(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 1, 0);
    cname[0] = "cyc_def"; cname[1] = "cyc_med"; cname[2] = "cyc_sml";
    for (int i = 0; i < 3; i++) begin
      ecyc[i] = 0; fbase[i] = 16'd0; started[i] = 1'b0;
    end
  end

  // Watchdog: the run must always end with a summary.
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    fork
      begin : seq_def
        int n, low_cnt, act_cnt;
        logic [7:0] pat;
        logic [9:0] first_x, last_x;
        longint t1;
        bit ok;
        @(posedge clk); #1 rst0 = 1'b0;
        @(negedge clk);
        check("def_rst_x", x0, 0);
        check("def_rst_y", y0, 0);
        check("def_rst_active", act0, 1);
        check("def_rst_hsync", hs0, 1);
        check("def_rst_vsync", vs0, 1);
        check("def_rst_pce", pce0, 0);
        check("def_rst_fc", fc0, 0);
        check("def_rst_actd", actd0, 0);
        pat[0] = pce0;
        for (int k = 1; k < 8; k++) begin @(negedge clk); pat[k] = pce0; end
        check("def_pce_pattern", pat, 8'hAA);
        n = 0;
        while (hs0 !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        check("def_hs_found", hs0, 0);
        first_x = x0;
        check("def_hs_first_x", first_x, 656);
        low_cnt = 0; last_x = '0;
        while (hs0 === 1'b0 && low_cnt < 400) begin last_x = x0; low_cnt++; @(negedge clk); end
        check("def_hs_low_clka", low_cnt, 192);
        check("def_hs_last_x", last_x, 751);
        n = 0;
        while (ls0 !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("def_ls_found", ls0, 1);
        check("def_ls_x", x0, 799);
        t1 = cyc; act_cnt = 0; n = 0;
        do begin
          @(negedge clk); n++;
          if (act0 === 1'b1) act_cnt++;
        end while (ls0 !== 1'b1 && n < 2000);
        check("def_ls_period", cyc - t1, 1600);
        check("def_active_clka", act_cnt, 1280);
        check("def_ls2_y", y0, 1);
        n = 0;
        while (x0 !== 10'd100 && n < 400) begin @(negedge clk); n++; end
        check("def_x100_found", x0, 100);
        @(posedge clk); #1 en0 = 1'b0;
        ok = 1'b1;
        repeat (37) begin
          @(negedge clk);
          if (x0 !== 10'd100 || y0 !== 10'd2 || pce0 !== 1'b0 || ls0 !== 1'b0 || fs0 !== 1'b0) ok = 1'b0;
        end
        check("def_freeze_hold", ok, 1);
        @(posedge clk); #1 en0 = 1'b1;
        @(negedge clk);
        check("def_resume_pce", pce0, 1);
        check("def_resume_x", x0, 100);
        @(negedge clk);
        check("def_resume_x_next", x0, 101);
        repeat (20) @(negedge clk);
      end
      begin : seq_med
        int n, vs_cnt;
        logic [3:0] pat;
        longint t1;
        bit ok_act, ok_vs, saw_fs;
        @(posedge clk); #1 rst1 = 1'b0;
        @(negedge clk);
        check("med_rst_vsd", vsd1, 0);
        check("med_rst_hsd", hsd1, 1);
        check("med_rst_vs", vs1, 0);
        check("med_rst_hs", hs1, 1);
        pat[0] = actd1;
        for (int k = 1; k < 4; k++) begin @(negedge clk); pat[k] = actd1; end
        check("med_actd_delay3", pat, 4'b1000);
        n = 0;
        while (fs1 !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("med_fs_found", fs1, 1);
        check("med_fs_x", x1, 23);
        check("med_fs_y", y1, 16);
        check("med_fs_ls", ls1, 1);
        check("med_fs_fc0", fc1, 0);
        t1 = cyc; vs_cnt = 0; ok_act = 1'b1; ok_vs = 1'b1; n = 0;
        do begin
          @(negedge clk); n++;
          if (vs1 === 1'b1) begin
            vs_cnt++;
            if (y1 !== 5'd12 && y1 !== 5'd13) ok_vs = 1'b0;
          end
          if (act1 === 1'b1 && y1 >= 5'd10) ok_act = 1'b0;
        end while (fs1 !== 1'b1 && n < 2000);
        check("med_fs_period", cyc - t1, 816);
        check("med_vs_clka", vs_cnt, 96);
        check("med_vs_rows", ok_vs, 1);
        check("med_no_active_vblank", ok_act, 1);
        @(negedge clk);
        check("med_fc_two", fc1, 2);
        check("med_wrap_xy", {x1, y1}, 10'd0);
        @(posedge clk); #1 en1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 en1 = 1'b1;
        n = 0; saw_fs = 1'b0;
        while (!(x1 === 5'd22 && y1 === 5'd8) && n < 1000) begin
          @(negedge clk); n++;
          if (fs1 === 1'b1) saw_fs = 1'b1;
        end
        check("med_mid_found", {x1, y1}, {5'd22, 5'd8});
        @(posedge clk); #1 rst1 = 1'b1;
        @(negedge clk);
        if (fs1 === 1'b1) saw_fs = 1'b1;
        @(posedge clk); #1 rst1 = 1'b0;
        @(negedge clk);
        check("med_rst_mid_x", x1, 0);
        check("med_rst_mid_y", y1, 0);
        check("med_rst_mid_fc", fc1, 0);
        check("med_rst_mid_hs", hs1, 1);
        check("med_rst_mid_act", act1, 1);
        check("med_rst_mid_actd", actd1, 0);
        check("med_rst_no_fs", saw_fs, 0);
        @(posedge clk); #1 en1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 en1 = 1'b1;
        repeat (12) @(negedge clk);
      end
      begin : seq_sml
        int n;
        logic [7:0] pat;
        logic [5:0] vpat;
        longint t1;
        @(posedge clk); #1 rst2 = 1'b0;
        @(negedge clk);
        check("sml_rst_pce", pce2, 1);
        check("sml_rst_hs", hs2, 0);
        check("sml_rst_vs", vs2, 0);
        check("sml_rst_actd", actd2, 1);
        pat[0] = hs2;
        for (int k = 1; k < 8; k++) begin @(negedge clk); pat[k] = hs2; end
        check("sml_hs_pattern", pat, 8'h60);
        @(negedge clk);
        for (int ln = 0; ln < 6; ln++) begin
          vpat[(ln + 1) % 6] = vs2;
          repeat (8) @(negedge clk);
        end
        check("sml_vs_rows", vpat, 6'b010000);
        n = 0;
        while (ls2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("sml_ls_found", ls2, 1);
        t1 = cyc; n = 0;
        do begin @(negedge clk); n++; end while (ls2 !== 1'b1 && n < 20);
        check("sml_ls_period", cyc - t1, 8);
        n = 0;
        while (fs2 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("sml_fs_found", fs2, 1);
        t1 = cyc; n = 0;
        do begin @(negedge clk); n++; end while (fs2 !== 1'b1 && n < 100);
        check("sml_fs_period", cyc - t1, 48);
        @(posedge clk);
        #1 force u_sml.frame_cnt_q = 16'hFFFF;
        fbase[2] = 16'hFFFF - 16'(ecyc[2] / 48);
        #1 release u_sml.frame_cnt_q;
        n = 0;
        while (fs2 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("sml_pre_wrap_fc", fc2, 16'hFFFF);
        check("sml_eof_ls", ls2, 1);
        @(negedge clk);
        check("sml_wrap_fc", fc2, 0);
        check("sml_wrap_xy", {x2, y2}, 6'd0);
        repeat (10) @(negedge clk);
      end
    join
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Owns its horizontal and vertical pixel counters internally, so display blocks no longer need externally supplied x/y.
- Produces pixel coordinates, a pixel clock-enable, sync and active-video signals, line/frame strobes and a frame counter.
- Also produces copies of sync/active delayed by PIPE_DLY cycles, so they stay aligned with downstream framebuffer/char-ROM read latency.
- Sits between the system clock and the run/debug display datapath feeding the VGA pins.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: hsync pulse width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vsync pulse width (lines)
- V_BP, 33: vertical back porch (lines)
- HS_POL, 0: hsync asserted level (0 = active-low)
- VS_POL, 0: vsync asserted level (0 = active-low)
- PIX_DIV, 2: clka cycles per pixel; must be >= 1
- PIPE_DLY, 1: clka-cycle delay applied to the *_d outputs; range 0..15
- X_W, 10: x width; must hold H_TOTAL-1
- Y_W, 10: y width; must hold V_TOTAL-1

Ports:
- clka  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- en  in  1  count enable; 0 freezes the raster
- pix_ce  out  1  pixel clock-enable
- x  out  X_W  current pixel column, registered counter
- y  out  Y_W  current line, registered counter
- active  out  1  x,y lie in the visible region
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- active_d  out  1  active delayed by PIPE_DLY cycles
- hsync_d  out  1  hsync delayed by PIPE_DLY cycles
- vsync_d  out  1  vsync delayed by PIPE_DLY cycles
- line_start  out  1  one-cycle pulse on the last pixel of each line
- frame_start  out  1  one-cycle pulse on the last pixel of each frame
- frame_count  out  16  number of completed frames, wraps modulo 2^16

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Prescaler div_cnt counts 0..PIX_DIV-1 on every clka edge while en=1, wrapping to 0.
- pix_ce = en && (div_cnt == PIX_DIV-1), combinational. With PIX_DIV=1, pix_ce = en.
- On a clka edge with pix_ce=1:
  - if x == H_TOTAL-1: x <= 0, and y advances (see next bullet)
  - otherwise x <= x+1
- y advance: if y == V_TOTAL-1, y <= 0 and frame_count <= frame_count+1; otherwise y <= y+1.
- en=0: div_cnt, x, y and frame_count hold. All decodes continue from the held values. Strobes are 0 because pix_ce=0.
- Combinational decodes from the x/y registers (zero latency relative to x,y):
  - active = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hs_raw = H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1; hsync = hs_raw when HS_POL=1, else ~hs_raw
  - vs_raw = V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1; vsync likewise, polarity VS_POL
  - line_start = pix_ce && x == H_TOTAL-1
  - frame_start = line_start && y == V_TOTAL-1
- Delay line: a PIPE_DLY-stage shift register of {active, hsync, vsync}, advancing every clka cycle regardless of en.
  - PIPE_DLY=0: *_d equal the undelayed signals.
- Reset, synchronous, takes priority over en. Values on the next edge:
  - div_cnt=0, x=0, y=0, frame_count=0
  - every delay stage loaded with active=0, hsync=~HS_POL, vsync=~VS_POL
- Immediately after reset, x=0, y=0, so active=1, hsync and vsync are deasserted, and pix_ce = (PIX_DIV==1) && en.
- *_d outputs show the inactive values for PIPE_DLY cycles after reset.
- Reset mid-frame aborts the frame: no frame_start is emitted and frame_count is not incremented.
- Simultaneous end-of-line and end-of-frame: x, y and frame_count all update on the same edge; line_start and frame_start both pulse in that cycle.
- frame_count wraps from 0xFFFF to 0x0000 with no other side effect.

Test Plan:
- Defaults, en=1, after reset:
  - pix_ce high every 2nd cycle
  - line_start period 1600 clka
  - hsync low for exactly 96 pixel ticks (192 clka), from x=656 through x=751
  - active high for x 0..639
- Defaults, run 2 frames:
  - vsync low exactly on y=490 and 491
  - frame_start period 840000 clka
  - frame_count reads 2
  - active never high for y >= 480
- Freeze: drop en for 37 cycles at x=100 -> x, y and div_cnt hold; no strobes; counting resumes from x=100 once en returns.
- Reset asserted at x=700, y=300 -> next edge x=0, y=0, frame_count=0, hsync=1, active=1, no frame_start pulse.
- PIPE_DLY=3 -> active_d/hsync_d/vsync_d equal active/hsync/vsync delayed exactly 3 clka cycles, including across en=0 and after reset.
- Small config (H 4/1/2/1, V 3/1/1/1, PIX_DIV=1, HS_POL=1, VS_POL=1):
  - hsync high at x=5,6; vsync high at y=4
  - line_start every 8 cycles, frame_start every 48 cycles
  - preload frame_count to 0xFFFF via 65535 frames (or force) -> next frame_start wraps it to 0
